// File: rtl/fixed_divide_seq.sv
`default_nettype none
// ============================================================================
// Module   : fixed_divide_seq
// Brief    : Sequential signed fixed-point restoring divider with saturation;
//            FIXED_DIVIDE_ROUND_EN enables round-half-away-from-zero.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_divide_seq #(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INT_W+FRAC_W-1:0]   dividend,
    input  logic [INT_W+FRAC_W-1:0]   divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INT_W+FRAC_W-1:0]   quotient,
    output logic                      overflow,
    output logic                      div_by_zero
);

    localparam int W     = INT_W + FRAC_W;
    localparam int ITERS = W + FRAC_W;
    localparam int RW    = W + 1;
    localparam int QW    = ITERS + 1;
    localparam int CNT_W = $clog2(ITERS + 1);

    localparam logic [W-1:0]     SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     SAT_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [QW-1:0]    LIM_POS = {{(QW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [QW-1:0]    LIM_NEG = {{(QW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ITERS-1:0]   dvd_q, dvd_d;
    logic [RW-1:0]      dvs_q, dvs_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [ITERS-1:0]   quo_q, quo_d;
    logic               neg_q, neg_d;
    logic               zero_q, zero_d;
    logic               a_neg_q, a_neg_d;
    logic               a_zero_q, a_zero_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       quotient_q, quotient_d;
    logic               overflow_q, overflow_d;
    logic               dbz_q, dbz_d;

    // Magnitudes carry one extra bit so the most negative operand is exact.
    logic [RW-1:0]      w_a_ext, w_b_ext, w_a_mag, w_b_mag;
    logic [RW:0]        w_trial, w_diff;
    logic               w_ge;
    logic               w_round;
    logic [QW-1:0]      w_q_mag;
    logic [W-1:0]       w_q_lo;

    assign w_a_ext = {dividend[W-1], dividend};
    assign w_b_ext = {divisor[W-1], divisor};
    assign w_a_mag = dividend[W-1] ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_b_mag = divisor[W-1]  ? (~w_b_ext + 1'b1) : w_b_ext;

    assign w_trial = {rem_q, dvd_q[ITERS-1]};
    assign w_diff  = w_trial - {1'b0, dvs_q};
    assign w_ge    = (w_trial >= {1'b0, dvs_q});

`ifdef FIXED_DIVIDE_ROUND_EN
    assign w_round = ({rem_q, 1'b0} >= {1'b0, dvs_q});
`else
    assign w_round = 1'b0;
`endif
    assign w_q_mag = {1'b0, quo_q} + QW'(w_round);
    assign w_q_lo  = w_q_mag[W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        a_neg_d     = a_neg_q;
        a_zero_d    = a_zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    neg_d      = dividend[W-1] ^ divisor[W-1];
                    dvd_d      = {w_a_mag[W-1:0], {FRAC_W{1'b0}}};
                    dvs_d      = w_b_mag;
                    zero_d     = (divisor == '0);
                    a_neg_d    = dividend[W-1];
                    a_zero_d   = (dividend == '0);
                    rem_d      = '0;
                    quo_d      = '0;
                    cnt_d      = CNT_INIT;
                    in_ready_d = 1'b0;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = w_ge ? w_diff[RW-1:0] : w_trial[RW-1:0];
                quo_d = {quo_q[ITERS-2:0], w_ge};
                dvd_d = {dvd_q[ITERS-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                overflow_d = 1'b0;
                dbz_d      = 1'b0;
                if (zero_q) begin
                    dbz_d      = 1'b1;
                    quotient_d = a_zero_q ? '0 : (a_neg_q ? SAT_NEG : SAT_POS);
                end else if (!neg_q && (w_q_mag > LIM_POS)) begin
                    quotient_d = SAT_POS;
                    overflow_d = 1'b1;
                end else if (neg_q && (w_q_mag > LIM_NEG)) begin
                    quotient_d = SAT_NEG;
                    overflow_d = 1'b1;
                end else begin
                    quotient_d = neg_q ? (~w_q_lo + 1'b1) : w_q_lo;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                // Result and flags hold until the consumer takes them.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            a_neg_q     <= 1'b0;
            a_zero_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            a_neg_q     <= a_neg_d;
            a_zero_q    <= a_zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_divide_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_divide_seq
// Brief    : Scoreboard bench for fixed_divide_seq with directed Q8.8 vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_divide_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic        overflow;
    logic        div_by_zero;

    typedef struct packed {
        logic [15:0] q;
        logic        ov;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    fixed_divide_seq #(.INT_W(8), .FRAC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .overflow   (overflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(quotient), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("overflow", 32'(overflow), 32'(e.ov));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    endtask

    // Issue one division, push its expectation, and return #1 after out_valid rises.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic eo, input logic ez);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        sb.push_back('{q: eq, ov: eo, dz: ez});
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk); #1; k++;
        end
        chk("latency", 32'(k), 32'd25);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int highs;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values();

        send(16'h0320, 16'h0280, 16'h0140, 1'b0, 1'b0);
        send(16'hFF00, 16'h0080, 16'hFE00, 1'b0, 1'b0);
`ifdef FIXED_DIVIDE_ROUND_EN
        send(16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0);
`else
        send(16'h0200, 16'h0300, 16'h00AA, 1'b0, 1'b0);
`endif
        send(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);
        send(16'h6400, 16'h0003, 16'h7FFF, 1'b1, 1'b0);
        send(16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0);
        send(16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
        send(16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1);
        send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        send(16'hFC00, 16'h0200, 16'hFE00, 1'b0, 1'b0);

        // Backpressure window with an ignored request.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h0320, 16'h0280, 16'h0140, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_quotient", 32'(quotient), 32'h0140);
            chk("bp_flags", {30'd0, overflow, div_by_zero}, 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            in_valid = 1'b1;
            dividend = 16'h0100;
            divisor  = 16'h0100;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        send(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);

        // Reset in the middle of CALC aborts the division.
        @(posedge clk); #1;
        while (!in_ready) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        dividend = 16'h0320;
        divisor  = 16'h0280;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values();
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) highs++;
        end
        chk("no_out_after_rst", 32'(highs), 32'd0);
        send(16'h0320, 16'h0280, 16'h0140, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fixed_divide_seq.md
Name: fixed_divide_seq

Overview:
- Sequential signed fixed-point divider for the DNN datapath: the inverse of the package multiply, used for normalisation and averaging stages.
- Operands and result use the package fixed-point format: signed two's complement, INT_W integer bits over FRAC_W fraction bits (Q8.8 by default, {integer_fixed, decimal_fixed}).
- Restoring division, one quotient bit per cycle, with valid/ready handshakes on both sides.
- Saturates on overflow and divide-by-zero.

Parameters:
- INT_W, 8, integer bits of operands/result.
- FRAC_W, 8, fraction bits of operands/result.
- (Derived: W = INT_W+FRAC_W; ITERS = W+FRAC_W, 24 by default.)

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  W  signed fixed-point a.
- divisor  input  W  signed fixed-point b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  W  signed fixed-point a/b, saturated.
- overflow  output  1  result saturated due to magnitude overflow.
- div_by_zero  output  1  divisor was zero.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, quotient=0, overflow=0, div_by_zero=0. Iteration counter, remainder and quotient registers are cleared.
- Reset mid-operation aborts the current division: no out_valid pulse, and the next cycle is IDLE.

FSM: IDLE -> CALC -> FINAL -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture:
  - sign = dividend[W-1]^divisor[W-1]
  - |dividend| zero-extended to W+FRAC_W bits, shifted left FRAC_W
  - |divisor| as W+1 bits
  - zero flag = (divisor==0)
  - counter=ITERS
  - next state CALC.
- Magnitudes use W+1 bits so |-2^(W-1)| = 2^(W-1) is exact.
- CALC: each cycle shift the dividend MSB into the remainder. If remainder >= |divisor|, subtract and set the quotient bit to 1, else 0. Decrement counter; after ITERS cycles go to FINAL.
- CALC runs the full ITERS cycles even when divisor==0 (fixed latency).
- FINAL (1 cycle): produce the raw magnitude Q (rounding optional, see below), then apply sign and saturation, and register the outputs.
  - If the zero flag is set: div_by_zero=1, overflow=0. quotient = 0 if dividend==0; 2^(W-1)-1 (0x7FFF) if dividend>0; -2^(W-1) (0x8000) if dividend<0.
  - If positive and Q > 2^(W-1)-1: quotient=0x7FFF, overflow=1.
  - If negative and Q > 2^(W-1): quotient=0x8000, overflow=1.
  - Otherwise quotient = sign ? -Q : Q, with overflow=0 and div_by_zero=0.
  - Next state DONE.
- DONE: out_valid=1; quotient/flags stable while out_valid && !out_ready. On out_ready go to IDLE: out_valid=0 next cycle, flags keep their values until the next FINAL.
- in_ready=0 in CALC/FINAL/DONE: one division in flight at a time, and no same-cycle accept on output handoff.
- Latency: accept edge E0; out_valid is observed high after edge E0+ITERS+1 (25 edges by default). Minimum initiation interval is ITERS+3 cycles.
- Default rounding is truncation toward zero: Q = floor(|a|*2^FRAC_W / |b|).
- in_valid while in_ready=0 is ignored. Operands need only be stable on the accepting edge.

Optional Feature:
- Macro: FIXED_DIVIDE_ROUND_EN.
- Defined: in FINAL, if 2*remainder >= |divisor|, Q = Q+1 (round half away from zero). This is applied before saturation, so Q+1 may trigger overflow.
- Undefined: truncation toward zero. Rounding logic is absent and behaviour is identical otherwise.
- Latency is unchanged either way.

Test Plan:
- 0x0320 / 0x0280 (3.125/2.5) -> quotient 0x0140 (1.25), flags 0, out_valid exactly 25 edges after accept.
- 0xFF00 / 0x0080 (-1.0/0.5) -> 0xFE00 (-2.0).
- 0x0200 / 0x0300 (2/3) -> 0x00AA without FIXED_DIVIDE_ROUND_EN, 0x00AB with it.
- 0x0100 / 0x0300 -> 0x0055 in both builds.
- Overflow and divide-by-zero:
  - 0x6400 / 0x0003 -> 0x7FFF, overflow=1.
  - 0x8000 / 0xFFFF -> 0x7FFF, overflow=1.
  - 0x0100 / 0x0000 -> 0x7FFF, div_by_zero=1.
  - 0xFF00 / 0x0000 -> 0x8000, div_by_zero=1.
  - 0x0000 / 0x0000 -> 0x0000, div_by_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> quotient/flags stable and in_ready=0 throughout. Drive a new in_valid during this window -> ignored. out_ready=1 -> IDLE next cycle, then accept the next pair.
- Reset: assert rst at CALC cycle 10 -> all outputs at reset values, no out_valid. A following 0x0320/0x0280 completes correctly with the same 25-edge latency.
